// File: rtl/vend_coin_scheduler.sv
// rtl/vend_coin_scheduler.sv - coin FIFO and issue scheduler in front of the soda vending core
//
// Buffers acceptor coin events (several per cycle allowed) and replays them to
// the core as one-hot single-cycle pulses, holding issue while the core vends.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_nickle, i_dime, i_quarter       acceptor coin events
//   o_nickle, o_dime, o_quarter       registered one-hot coin pulses to the core
//   i_soda, i_change                  core dispense pulse and change (5c units)
//   o_level, o_full                   FIFO occupancy and full flag
//   o_vend_count                      vends completed (wrapping)
//   o_change_total, o_drop_count      saturating change sum and dropped-coin count
//   o_err                             sticky protocol error
module vend_coin_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_nickle,
  input  logic                   i_dime,
  input  logic                   i_quarter,
  output logic                   o_nickle,
  output logic                   o_dime,
  output logic                   o_quarter,
  input  logic                   i_soda,
  input  logic [2:0]             i_change,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic [15:0]            o_vend_count,
  output logic [7:0]             o_change_total,
  output logic [7:0]             o_drop_count,
  output logic                   o_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_VEND} state_t;
  state_t state, state_nxt;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    shadow, shadow_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          pop, err_set;

  // Enqueue: quarter first, then dime, then nickel; space is judged against the
  // occupancy at the start of the cycle, so a same-cycle pop frees nothing.
  logic [2:0]    coin_req;
  logic [LW-1:0] free_space;
  logic [1:0]    wr_code [3];
  logic [1:0]    n_wr, n_req, n_drop;

  assign coin_req = {i_quarter, i_dime, i_nickle};

  always_comb begin
    free_space = LW'(DEPTH) - o_level;
    n_wr       = '0;
    n_req      = '0;
    wr_code[0] = '0;
    wr_code[1] = '0;
    wr_code[2] = '0;
    for (int k = 2; k >= 0; k--) begin
      if (coin_req[k]) begin
        n_req = n_req + 2'd1;
        if (LW'(n_wr) < free_space) begin
          // bit index + 1 is the entry code: nickel 1, dime 2, quarter 3
          case (n_wr)
            2'd0:    wr_code[0] = 2'(k + 1);
            2'd1:    wr_code[1] = 2'(k + 1);
            default: wr_code[2] = 2'(k + 1);
          endcase
          n_wr = n_wr + 2'd1;
        end
      end
    end
    n_drop = n_req - n_wr;
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_wr) mem[wr_ptr + PW'(k)] <= wr_code[k];
    end
  end

  logic [1:0] head;
  logic [5:0] head_val, total;

  assign head = mem[rd_ptr];

  always_comb begin
    case (head)
      2'd1:    head_val = 6'd5;
      2'd2:    head_val = 6'd10;
      2'd3:    head_val = 6'd25;
      default: head_val = 6'd0;
    endcase
    total = {1'b0, shadow} + head_val;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    tmo_cnt_nxt = tmo_cnt;
    pop         = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (i_soda) err_set = 1'b1;
        if (o_level != '0) pop = 1'b1;
      end
      WAIT_VEND: begin
        if (i_soda) begin
          // the core is back at 0c in this cycle, so the next coin may go now
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
          if (o_level != '0) pop = 1'b1;
        end else if (tmo_cnt <= TW'(1)) begin
          err_set     = 1'b1;
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
        end else begin
          tmo_cnt_nxt = tmo_cnt - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (pop) begin
      if (total >= 6'd20) begin
        shadow_nxt  = '0;
        tmo_cnt_nxt = TW'(TIMEOUT);
        state_nxt   = WAIT_VEND;
      end else begin
        shadow_nxt = total[4:0];
      end
    end
  end

  logic [8:0] chg_sum, drop_sum;

  assign chg_sum  = {1'b0, o_change_total} + 9'(i_change);
  assign drop_sum = {1'b0, o_drop_count} + 9'(n_drop);
  assign o_full   = (o_level == LW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_level        <= '0;
      shadow         <= '0;
      tmo_cnt        <= '0;
      o_nickle       <= 1'b0;
      o_dime         <= 1'b0;
      o_quarter      <= 1'b0;
      o_vend_count   <= '0;
      o_change_total <= '0;
      o_drop_count   <= '0;
      o_err          <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(n_wr);
      rd_ptr    <= rd_ptr + PW'(pop);
      o_level   <= o_level + LW'(n_wr) - LW'(pop);
      shadow    <= shadow_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      o_nickle  <= pop && (head == 2'd1);
      o_dime    <= pop && (head == 2'd2);
      o_quarter <= pop && (head == 2'd3);
      if (i_soda) begin
        o_vend_count   <= o_vend_count + 16'd1;
        o_change_total <= (chg_sum > 9'd255) ? 8'd255 : chg_sum[7:0];
      end
      o_drop_count <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
      if (err_set) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vend_coin_scheduler.sv
// tb/tb_vend_coin_scheduler.sv - self-checking bench for vend_coin_scheduler
module tb_vend_coin_scheduler;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 7;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_nickle = 1'b0, i_dime = 1'b0, i_quarter = 1'b0, i_soda = 1'b0;
  logic [2:0] i_change = 3'd0;
  logic       o_nickle, o_dime, o_quarter, o_full, o_err;
  logic [3:0] o_level;
  logic [15:0] o_vend_count;
  logic [7:0] o_change_total, o_drop_count;

  vend_coin_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_nickle(i_nickle), .i_dime(i_dime), .i_quarter(i_quarter),
    .o_nickle(o_nickle), .o_dime(o_dime), .o_quarter(o_quarter),
    .i_soda(i_soda), .i_change(i_change),
    .o_level(o_level), .o_full(o_full),
    .o_vend_count(o_vend_count), .o_change_total(o_change_total),
    .o_drop_count(o_drop_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: coin queue plus credit/vend bookkeeping in cents.
  int mq[$];
  bit m_wait, m_err;
  int m_credit, m_left, m_vend, m_chg, m_drop, m_out;

  function automatic void model_reset();
    mq.delete();
    m_wait = 0; m_err = 0; m_credit = 0; m_left = 0;
    m_vend = 0; m_chg = 0; m_drop = 0; m_out = 0;
  endfunction

  function automatic int cents(int code);
    return (code == 1) ? 5 : (code == 2) ? 10 : 25;
  endfunction

  function automatic void model_step();
    int  room = DEPTH - mq.size();
    bit  was_wait = m_wait;
    bit  can_pop = (!m_wait || i_soda) && (mq.size() > 0);
    int  c;
    int  req[3];
    m_out = 0;
    if (i_soda) begin
      m_vend = (m_vend + 1) % 65536;
      m_chg  = (m_chg + int'(i_change) > 255) ? 255 : m_chg + int'(i_change);
    end
    if (was_wait) begin
      if (i_soda) m_wait = 0;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_err = 1; m_wait = 0; end
      end
    end else if (i_soda) m_err = 1;
    if (can_pop) begin
      c = mq.pop_front();
      m_out = c;
      if (m_credit + cents(c) >= 20) begin
        m_credit = 0; m_wait = 1; m_left = TIMEOUT;
      end else m_credit = m_credit + cents(c);
    end
    req[0] = i_quarter ? 3 : 0;
    req[1] = i_dime    ? 2 : 0;
    req[2] = i_nickle  ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      if (req[k] != 0) begin
        if (room > 0) begin mq.push_back(req[k]); room--; end
        else if (m_drop < 255) m_drop++;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int coin_code();
    if ((32'(o_nickle) + 32'(o_dime) + 32'(o_quarter)) > 1) return 7;
    return o_quarter ? 3 : o_dime ? 2 : o_nickle ? 1 : 0;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".coin"},  coin_code(), m_out);
    chk({tag, ".level"}, o_level, mq.size());
    chk({tag, ".full"},  o_full, (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, ".vend"},  o_vend_count, m_vend);
    chk({tag, ".chg"},   o_change_total, m_chg);
    chk({tag, ".drop"},  o_drop_count, m_drop);
    chk({tag, ".err"},   o_err, m_err);
  endtask

  task automatic set_in(input logic n, input logic d, input logic q, input logic s, input logic [2:0] c);
    i_nickle = n; i_dime = d; i_quarter = q; i_soda = s; i_change = c;
  endtask

  task automatic tick();
    if (i_rst_n) model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 3'd0);
    i_rst_n = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  typedef struct {
    logic n, d, q, s;
    logic [2:0] chg;
    int coin, level, vend, chg_tot, err;
  } vec_t;

  vec_t tbl[11];
  bit   full_seen;
  int   guard;
  int   d_pulses[$];

  initial begin
    //        n  d  q  s  chg  coin lvl vend chg err
    tbl[0]  = '{1, 1, 1, 0, 3'd0, 0, 3, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 3'd0, 3, 2, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 3'd0, 0, 2, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 3'd0, 0, 2, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 3'd1, 2, 1, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 3'd0, 1, 0, 1, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 3'd0, 0, 1, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 3'd0, 2, 0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 3'd0, 0, 0, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 1, 3'd3, 0, 0, 2, 4, 0};
    tbl[10] = '{0, 0, 0, 1, 3'd2, 0, 0, 3, 6, 1};

    // reset state
    do_reset();
    chk("reset.level", o_level, 0);
    chk("reset.coin", coin_code(), 0);
    chk("reset.counts", {o_vend_count, o_change_total, o_drop_count}, 0);
    chk("reset.flags", {o_full, o_err}, 0);

    // table: Q+D+N together, then shadow 15 + dime vend, then unexpected soda
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].s, tbl[i].chg);
      tick();
      chk($sformatf("tbl%0d.coin", i), coin_code(), tbl[i].coin);
      chk($sformatf("tbl%0d.level", i), o_level, tbl[i].level);
      chk($sformatf("tbl%0d.vend", i), o_vend_count, tbl[i].vend);
      chk($sformatf("tbl%0d.chg", i), o_change_total, tbl[i].chg_tot);
      chk($sformatf("tbl%0d.err", i), o_err, tbl[i].err);
    end

    // dime, dime into empty FIFO with core answering 2 cycles after the vend coin
    do_reset();
    d_pulses.delete();
    for (int cyc = 0; cyc < 7; cyc++) begin
      set_in(0, (cyc < 2) ? 1'b1 : 1'b0, 0, (cyc == 5) ? 1'b1 : 1'b0, 3'd0);
      tick();
      if (o_dime) d_pulses.push_back(cyc + 1);
    end
    chk("dd.npulses", d_pulses.size(), 2);
    if (d_pulses.size() == 2) begin
      chk("dd.pulse0", d_pulses[0], 2);
      chk("dd.pulse1", d_pulses[1], 3);
    end
    chk("dd.vend", o_vend_count, 1);
    chk("dd.chg", o_change_total, 0);
    chk("dd.err", o_err, 0);

    // fill with quarters while the core never answers
    do_reset();
    full_seen = 0;
    for (int t = 1; t <= 12; t++) begin
      set_in(0, 0, 1, 0, 3'd0);
      tick();
      compare_all($sformatf("fill%0d", t));
      if (o_full) full_seen = 1;
      if (t == 8) chk("fill.err_early", o_err, 0);
      if (t == 9) chk("fill.err_timeout", o_err, 1);
    end
    chk("fill.full_seen", full_seen, 1);
    chk("fill.dropped", (o_drop_count > 0) ? 1 : 0, 1);
    set_in(0, 0, 0, 0, 3'd0);
    guard = 0;
    while (o_level != 0 && guard < 300) begin
      tick();
      compare_all("drain");
      guard++;
    end
    chk("drain.done", o_level, 0);

    // async reset while waiting for a vend with 3 entries queued
    do_reset();
    set_in(1, 1, 1, 0, 3'd0);
    tick();
    set_in(1, 0, 0, 0, 3'd0);
    tick();
    chk("midrst.pre_level", o_level, 3);
    set_in(0, 0, 0, 0, 3'd0);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.coin", coin_code(), 0);
    chk("midrst.level", o_level, 0);
    chk("midrst.outs", {o_full, o_err, o_vend_count, o_change_total, o_drop_count}, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("midrst.quiet", {28'd0, o_level} + 32'(coin_code()), 0);
    end

    // unexpected soda when idle and empty, then change-total saturation
    do_reset();
    set_in(0, 0, 0, 1, 3'd2);
    tick();
    chk("unexp.err", o_err, 1);
    chk("unexp.vend", o_vend_count, 1);
    chk("unexp.chg", o_change_total, 2);
    for (int t = 1; t < 130; t++) tick();
    chk("sat.chg", o_change_total, 255);
    chk("sat.vend", o_vend_count, 130);

    // randomized traffic against the reference model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
             3'($urandom_range(0, 7)));
      tick();
      compare_all($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
